// File: rtl/vme_pkg.sv
// Shared types and constants for the VME A16 slave controller.
package vme_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ_WAIT,
    WRITE,
    ACK,
    ERR,
    RELEASE
  } state_t;

  localparam logic [5:0] AM_A16_USER  = 6'h29;
  localparam logic [5:0] AM_A16_SUPER = 6'h2D;

  // Register window offsets within the board page
  localparam logic [7:0] REG_OFS_FIRST = 8'h80;
  localparam logic [7:0] REG_OFS_LAST  = 8'hA4;

  // Offsets that own a write strobe; the rest of the window is read-only
  localparam logic [7:0] WE_LO = 8'h80;
  localparam logic [7:0] WE_HI = 8'h8E;

  function automatic logic am_ok(input logic [5:0] am);
    return (am == AM_A16_USER) || (am == AM_A16_SUPER);
  endfunction

  function automatic logic we_range(input logic [7:0] ofs);
    return (ofs >= WE_LO) && (ofs <= WE_HI);
  endfunction

endpackage

// File: rtl/vme_sync.sv
// Multi-flop synchroniser for asynchronous VME strobes; presets to the
// deasserted (high) level so a reset never looks like an active strobe.
module vme_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  // Shift the async input through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/vme_slave_ctrl.sv
// VME A16 slave bus-cycle controller: strobe sync, address/AM decode,
// read-mux capture, register write strobe, DTACK*/BERR* generation.
module vme_slave_ctrl
  import vme_pkg::*;
#(
  parameter logic [7:0]  BASE_HI     = 8'h7C,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vme_as_n,
  input  logic [1:0]  vme_ds_n,
  input  logic        vme_write_n,
  input  logic [5:0]  vme_am,
  input  logic [15:0] vme_addr,
  input  logic [15:0] vme_din,
  input  logic [15:0] mux_dout,
  output logic [15:0] mux_addr,
  output logic [15:0] vme_dout,
  output logic        vme_doe,
  output logic        vme_dtack_n,
  output logic        vme_berr_n,
  output logic        reg_we,
  output logic [7:0]  reg_waddr,
  output logic [15:0] reg_wdata,
  output logic        busy
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);
  localparam logic [7:0] TMO_INIT = 8'(TIMEOUT);

  state_t      state;
  logic        as_s;
  logic [1:0]  ds_s;
  logic        wr_s;
  logic [5:0]  am_q;
  logic        wr_n_q;
  logic [1:0]  ds_q;
  logic [2:0]  lat_cnt;
  logic [7:0]  tmo_cnt;
  logic        armed;
  logic        hit;
  logic        bad;

  vme_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_as (
    .clk(clk), .rst(rst), .d(vme_as_n), .q(as_s)
  );
  vme_sync #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync_ds (
    .clk(clk), .rst(rst), .d(vme_ds_n), .q(ds_s)
  );
  vme_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_wr (
    .clk(clk), .rst(rst), .d(vme_write_n), .q(wr_s)
  );

  // Decode works on the address/AM latched when the cycle started
  assign hit  = (mux_addr[15:8] == BASE_HI) && am_ok(am_q);
  assign bad  = (ds_q != 2'b00) || mux_addr[0];
  assign busy = (state != IDLE);

  // Bus-cycle FSM with registered outputs; read latency is counted from
  // the MUX_ADDR latch so capture lands one cycle before DTACK* falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mux_addr    <= '0;
      vme_dout    <= '0;
      vme_doe     <= 1'b0;
      vme_dtack_n <= 1'b1;
      vme_berr_n  <= 1'b1;
      reg_we      <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      am_q        <= '0;
      wr_n_q      <= 1'b1;
      ds_q        <= 2'b11;
      lat_cnt     <= '0;
      tmo_cnt     <= '0;
      armed       <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          // A new cycle needs AS* seen high first, so an ignored or
          // aborted cycle cannot retrigger while AS* is still low
          if (as_s) armed <= 1'b1;
          if (armed && !as_s && ds_s != 2'b11) begin
            state    <= DECODE;
            mux_addr <= vme_addr;
            am_q     <= vme_am;
            wr_n_q   <= wr_s;
            ds_q     <= ds_s;
            lat_cnt  <= LAT_INIT;
            armed    <= 1'b0;
          end
        end
        DECODE: begin
          if (as_s || !hit) begin
            state <= IDLE;
          end else if (bad) begin
            state      <= ERR;
            vme_berr_n <= 1'b0;
            tmo_cnt    <= TMO_INIT;
          end else if (wr_n_q) begin
            state   <= READ_WAIT;
            vme_doe <= 1'b1;
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) vme_dout <= mux_dout;
          end else begin
            state <= WRITE;
            if (we_range(mux_addr[7:0])) begin
              reg_we    <= 1'b1;
              reg_waddr <= mux_addr[7:0];
              reg_wdata <= vme_din;
            end
          end
        end
        READ_WAIT: begin
          if (as_s) begin
            state   <= IDLE;
            vme_doe <= 1'b0;
          end else if (lat_cnt == 3'd0) begin
            state       <= ACK;
            vme_dtack_n <= 1'b0;
            tmo_cnt     <= TMO_INIT;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) vme_dout <= mux_dout;
          end
        end
        WRITE: begin
          if (as_s) begin
            state <= IDLE;
          end else begin
            state       <= ACK;
            vme_dtack_n <= 1'b0;
            tmo_cnt     <= TMO_INIT;
          end
        end
        ACK, ERR: begin
          if (ds_s == 2'b11 || tmo_cnt == 8'd1) begin
            state       <= RELEASE;
            vme_dtack_n <= 1'b1;
            vme_berr_n  <= 1'b1;
            vme_doe     <= 1'b0;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        RELEASE: begin
          if (as_s) begin
            state <= IDLE;
            armed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_slave_ctrl.sv
// Directed bench for vme_slave_ctrl with default parameters
// (SYNC_STAGES=2, READ_LAT=1, TIMEOUT=255).
module tb_vme_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vme_as_n = 1'b1;
  logic [1:0]  vme_ds_n = 2'b11;
  logic        vme_write_n = 1'b1;
  logic [5:0]  vme_am = '0;
  logic [15:0] vme_addr = '0;
  logic [15:0] vme_din = '0;
  logic [15:0] mux_dout = '0;
  logic [15:0] mux_addr;
  logic [15:0] vme_dout;
  logic        vme_doe;
  logic        vme_dtack_n;
  logic        vme_berr_n;
  logic        reg_we;
  logic [7:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int we_cnt = 0;
  int dtack_cyc = 0;
  int berr_cyc = 0;
  int doe_cyc = 0;
  logic [7:0]  we_addr_last = '0;
  logic [15:0] we_data_last = '0;

  vme_slave_ctrl dut (
    .clk(clk), .rst(rst),
    .vme_as_n(vme_as_n), .vme_ds_n(vme_ds_n), .vme_write_n(vme_write_n),
    .vme_am(vme_am), .vme_addr(vme_addr), .vme_din(vme_din),
    .mux_dout(mux_dout), .mux_addr(mux_addr), .vme_dout(vme_dout),
    .vme_doe(vme_doe), .vme_dtack_n(vme_dtack_n), .vme_berr_n(vme_berr_n),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt++;
      we_addr_last = reg_waddr;
      we_data_last = reg_wdata;
    end
    if (!vme_dtack_n) dtack_cyc++;
    if (!vme_berr_n) berr_cyc++;
    if (vme_doe) doe_cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    vme_as_n = 1'b1;
    vme_ds_n = 2'b11;
    vme_write_n = 1'b1;
  endtask

  task automatic start(input logic [15:0] a, input logic [5:0] am,
                       input logic wr_n, input logic [1:0] ds, input logic [15:0] d);
    @(posedge clk);
    #1;
    vme_addr = a;
    vme_am = am;
    vme_write_n = wr_n;
    vme_din = d;
    vme_as_n = 1'b0;
    vme_ds_n = ds;
  endtask

  task automatic wait_dtack(input logic val, input int limit, output int n);
    n = 0;
    while (vme_dtack_n !== val && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_berr(input logic val, input int limit, output int n);
    n = 0;
    while (vme_berr_n !== val && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic end_cycle();
    int n;
    vme_ds_n = 2'b11;
    wait_dtack(1'b1, 20, n);
    wait_berr(1'b1, 20, n);
    bus_idle();
    step(5);
  endtask

  task automatic test_reset();
    bus_idle();
    step(3);
    checks++; if (mux_addr !== 16'h0) begin errors++; $display("FAIL reset_mux_addr: got %h want 0000", mux_addr); end
    checks++; if (vme_dout !== 16'h0) begin errors++; $display("FAIL reset_vme_dout: got %h want 0000", vme_dout); end
    checks++; if (vme_doe !== 1'b0) begin errors++; $display("FAIL reset_doe: got %b want 0", vme_doe); end
    checks++; if (vme_dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack: got %b want 1", vme_dtack_n); end
    checks++; if (vme_berr_n !== 1'b1) begin errors++; $display("FAIL reset_berr: got %b want 1", vme_berr_n); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", reg_we); end
    checks++; if (reg_waddr !== 8'h0 || reg_wdata !== 16'h0) begin errors++; $display("FAIL reset_wregs: got %h/%h want 00/0000", reg_waddr, reg_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    step(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_read();
    int n, m, wb;
    wb = we_cnt;
    mux_dout = 16'hA5A5;
    start(16'h7C84, 6'h29, 1'b1, 2'b00, 16'h0);
    wait_dtack(1'b0, 40, n);
    checks++; if (n != 5) begin errors++; $display("FAIL read_latency: got %0d want 5", n); end
    checks++; if (mux_addr !== 16'h7C84) begin errors++; $display("FAIL read_mux_addr: got %h want 7C84", mux_addr); end
    checks++; if (vme_dout !== 16'hA5A5) begin errors++; $display("FAIL read_dout: got %h want A5A5", vme_dout); end
    checks++; if (vme_doe !== 1'b1) begin errors++; $display("FAIL read_doe: got %b want 1", vme_doe); end
    vme_ds_n = 2'b11;
    wait_dtack(1'b1, 20, m);
    checks++; if (m != 3) begin errors++; $display("FAIL read_release: got %0d want 3", m); end
    checks++; if (vme_doe !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL read_release_state: got doe=%b busy=%b want 0/1", vme_doe, busy); end
    bus_idle();
    step(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle: got busy=%b want 0", busy); end
    checks++; if (we_cnt - wb != 0) begin errors++; $display("FAIL read_no_we: got %0d want 0", we_cnt - wb); end
  endtask

  task automatic test_write();
    int n, wb;
    wb = we_cnt;
    start(16'h7C8A, 6'h2D, 1'b0, 2'b00, 16'h1234);
    wait_dtack(1'b0, 40, n);
    checks++; if (n != 5) begin errors++; $display("FAIL write_dtack: got %0d want 5", n); end
    checks++; if (we_cnt - wb != 1) begin errors++; $display("FAIL write_we_count: got %0d want 1", we_cnt - wb); end
    checks++; if (we_addr_last !== 8'h8A || we_data_last !== 16'h1234) begin errors++; $display("FAIL write_payload: got %h/%h want 8A/1234", we_addr_last, we_data_last); end
    end_cycle();
    checks++; if (we_cnt - wb != 1) begin errors++; $display("FAIL write_we_once: got %0d want 1", we_cnt - wb); end
  endtask

  task automatic test_write_no_strobe();
    int n, wb;
    wb = we_cnt;
    start(16'h7CA0, 6'h29, 1'b0, 2'b00, 16'h5555);
    wait_dtack(1'b0, 40, n);
    checks++; if (n != 5) begin errors++; $display("FAIL write_ro_dtack: got %0d want 5", n); end
    end_cycle();
    checks++; if (we_cnt - wb != 0) begin errors++; $display("FAIL write_ro_we: got %0d want 0", we_cnt - wb); end
  endtask

  task automatic test_read_zero();
    int n;
    mux_dout = 16'h0000;
    start(16'h7C92, 6'h2D, 1'b1, 2'b00, 16'h0);
    wait_dtack(1'b0, 40, n);
    checks++; if (n != 5) begin errors++; $display("FAIL read0_dtack: got %0d want 5", n); end
    checks++; if (vme_dout !== 16'h0000) begin errors++; $display("FAIL read0_dout: got %h want 0000", vme_dout); end
    end_cycle();
  endtask

  task automatic test_miss();
    logic [15:0] addrs [2];
    logic [5:0]  ams [2];
    int db, bb, ob;
    addrs[0] = 16'h7D80; ams[0] = 6'h29;
    addrs[1] = 16'h7C80; ams[1] = 6'h39;
    for (int i = 0; i < 2; i++) begin
      db = dtack_cyc; bb = berr_cyc; ob = doe_cyc;
      start(addrs[i], ams[i], 1'b1, 2'b00, 16'h0);
      step(15);
      checks++; if (dtack_cyc != db || berr_cyc != bb || doe_cyc != ob) begin errors++; $display("FAIL miss_%0d_response: got dtack=%0d berr=%0d doe=%0d want 0/0/0", i, dtack_cyc - db, berr_cyc - bb, doe_cyc - ob); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL miss_%0d_busy: got %b want 0", i, busy); end
      bus_idle();
      step(5);
    end
  endtask

  task automatic test_byte_access();
    int n, db;
    db = dtack_cyc;
    start(16'h7C80, 6'h29, 1'b1, 2'b10, 16'h0);
    wait_berr(1'b0, 40, n);
    checks++; if (n != 4) begin errors++; $display("FAIL byte_berr: got %0d want 4", n); end
    checks++; if (dtack_cyc != db || vme_doe !== 1'b0) begin errors++; $display("FAIL byte_no_dtack: got dtack=%0d doe=%b want 0/0", dtack_cyc - db, vme_doe); end
    end_cycle();
  endtask

  task automatic test_timeout();
    int n, h;
    mux_dout = 16'hBEEF;
    start(16'h7C80, 6'h29, 1'b1, 2'b00, 16'h0);
    wait_dtack(1'b0, 40, n);
    checks++; if (n != 5) begin errors++; $display("FAIL tmo_dtack: got %0d want 5", n); end
    wait_dtack(1'b1, 300, h);
    checks++; if (h != 255) begin errors++; $display("FAIL tmo_hold: got %0d want 255", h); end
    checks++; if (busy !== 1'b1 || vme_doe !== 1'b0) begin errors++; $display("FAIL tmo_release_state: got busy=%b doe=%b want 1/0", busy, vme_doe); end
    step(20);
    checks++; if (vme_dtack_n !== 1'b1) begin errors++; $display("FAIL tmo_stays_released: got %b want 1", vme_dtack_n); end
    bus_idle();
    step(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    int db, wb;
    db = dtack_cyc; wb = we_cnt;
    start(16'h7C86, 6'h29, 1'b1, 2'b00, 16'h0);
    step(2);
    vme_as_n = 1'b1;
    step(15);
    checks++; if (dtack_cyc != db) begin errors++; $display("FAIL abort_dtack: got %0d cycles want 0", dtack_cyc - db); end
    checks++; if (busy !== 1'b0 || vme_doe !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%b doe=%b want 0/0", busy, vme_doe); end
    checks++; if (we_cnt != wb) begin errors++; $display("FAIL abort_we: got %0d want 0", we_cnt - wb); end
    bus_idle();
    step(5);
  endtask

  task automatic test_reset_in_ack();
    int n;
    mux_dout = 16'h3C3C;
    start(16'h7C84, 6'h29, 1'b1, 2'b00, 16'h0);
    wait_dtack(1'b0, 40, n);
    checks++; if (n != 5) begin errors++; $display("FAIL rstack_dtack: got %0d want 5", n); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (vme_dtack_n !== 1'b1 || vme_doe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstack_strobes: got dtack=%b doe=%b busy=%b want 1/0/0", vme_dtack_n, vme_doe, busy); end
    checks++; if (mux_addr !== 16'h0 || vme_dout !== 16'h0) begin errors++; $display("FAIL rstack_data: got %h/%h want 0000/0000", mux_addr, vme_dout); end
    checks++; if (reg_waddr !== 8'h0 || reg_wdata !== 16'h0) begin errors++; $display("FAIL rstack_wregs: got %h/%h want 00/0000", reg_waddr, reg_wdata); end
    bus_idle();
    step(2);
    rst = 1'b0;
    step(5);
    checks++; if (busy !== 1'b0 || vme_dtack_n !== 1'b1) begin errors++; $display("FAIL rstack_after: got busy=%b dtack=%b want 0/1", busy, vme_dtack_n); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_write_no_strobe();
    test_read_zero();
    test_miss();
    test_byte_access();
    test_timeout();
    test_abort();
    test_reset_in_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
